// File: rtl/present_enc_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative PRESENT-80 encrypt core between N_REQ requesters.
// Latency: accept at cycle 0, core_start at cycle 1, response valid one cycle after core_done (or timeout).
// Backpressure: one job in flight; req_ready only in IDLE; response held stable until resp_ready.
module present_enc_arbiter #(
  parameter int N_REQ   = 2,
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 80,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*BLOCK_W-1:0] req_plaintext,
  input  logic [N_REQ*KEY_W-1:0]   req_key,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [BLOCK_W-1:0]       resp_ciphertext,
  output logic [ID_W-1:0]          resp_id,
  output logic                     resp_err,
  output logic                     core_start,
  output logic [BLOCK_W-1:0]       core_plaintext,
  output logic [KEY_W-1:0]         core_key,
  input  logic                     core_done,
  input  logic [BLOCK_W-1:0]       core_ciphertext
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    idx;
  logic               grant_vld;
  logic [BLOCK_W-1:0] sel_pt;
  logic [KEY_W-1:0]   sel_key;

  // Round-robin search starting just after the last winner; the lowest offset wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_grant) + k) % N_REQ);
      if (req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  // Operand mux for the granted requester and the one-hot ready, only offered in IDLE and never under reset.
  always_comb begin
    sel_pt    = '0;
    sel_key   = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_pt  = req_plaintext[i*BLOCK_W +: BLOCK_W];
        sel_key = req_key[i*KEY_W +: KEY_W];
        req_ready[i] = (state == S_IDLE) && grant_vld && !rst;
      end
    end
  end

  // Job sequencer: capture, launch pulse, wait for done or timeout, hold response until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      last_grant      <= ID_W'(N_REQ - 1);
      cnt             <= '0;
      resp_valid      <= 1'b0;
      resp_ciphertext <= '0;
      resp_id         <= '0;
      resp_err        <= 1'b0;
      core_start      <= 1'b0;
      core_plaintext  <= '0;
      core_key        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            core_plaintext <= sel_pt;
            core_key       <= sel_key;
            resp_id        <= grant;
            last_grant     <= grant;
            core_start     <= 1'b1;
            state          <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          core_start <= 1'b0;
          cnt        <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (core_done) begin
            resp_ciphertext <= core_ciphertext;
            resp_err        <= 1'b0;
            resp_valid      <= 1'b1;
            state           <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            resp_ciphertext <= '0;
            resp_err        <= 1'b1;
            resp_valid      <= 1'b1;
            state           <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_enc_arbiter.sv
// Directed bench for present_enc_arbiter with a behavioural core returning known PRESENT-80 vectors.
// Core latency is programmable; the core can hang or emit a stray done pulse.
// Inputs are driven at the falling edge; outputs are sampled 1ns after it.
module tb_present_enc_arbiter;

  localparam int N_REQ   = 2;
  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int TO      = 16;
  localparam int ID_W    = 1;

  localparam logic [63:0] PT_0  = 64'h0;
  localparam logic [63:0] PT_F  = {64{1'b1}};
  localparam logic [79:0] KEY_0 = 80'h0;
  localparam logic [79:0] KEY_F = {80{1'b1}};

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*BLOCK_W-1:0] req_plaintext;
  logic [N_REQ*KEY_W-1:0]   req_key;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [BLOCK_W-1:0]       resp_ciphertext;
  logic [ID_W-1:0]          resp_id;
  logic                     resp_err;
  logic                     core_start;
  logic [BLOCK_W-1:0]       core_plaintext;
  logic [KEY_W-1:0]         core_key;
  logic                     core_done = 1'b0;
  logic [BLOCK_W-1:0]       core_ciphertext = '0;

  int checks;
  int errors;

  // Core model controls (written only by the stimulus process).
  int lat;
  bit hang;
  int stray_req;

  // Core model state (written only by the model process).
  int          rem = 0;
  bit          busy = 1'b0;
  int          stray_ack = 0;
  logic [63:0] cap_pt = '0;
  logic [79:0] cap_key = '0;

  present_enc_arbiter #(
    .N_REQ(N_REQ), .BLOCK_W(BLOCK_W), .KEY_W(KEY_W), .TIMEOUT(TO), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_ciphertext(resp_ciphertext), .resp_id(resp_id), .resp_err(resp_err),
    .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
    .core_done(core_done), .core_ciphertext(core_ciphertext)
  );

  always #5 clk = ~clk;

  // Published PRESENT-80 test vectors.
  function automatic logic [63:0] present_ref(input logic [63:0] pt, input logic [79:0] key);
    if (pt == PT_0 && key == KEY_0) return 64'h5579C1387B228445;
    if (pt == PT_0 && key == KEY_F) return 64'hE72C46C0F5945049;
    if (pt == PT_F && key == KEY_0) return 64'hA112FFC72F68417B;
    if (pt == PT_F && key == KEY_F) return 64'h3333DCD3213210D2;
    return 64'h0BAD_0BAD_0BAD_0BAD;
  endfunction

  // Behavioural core: done pulse lat cycles after the start cycle, garbage data otherwise.
  always @(negedge clk) begin
    core_done       = 1'b0;
    core_ciphertext = 64'hDEAD_BEEF_DEAD_BEEF;
    if (rst) begin
      busy = 1'b0;
    end else if (core_start) begin
      busy    = 1'b1;
      rem     = lat;
      cap_pt  = core_plaintext;
      cap_key = core_key;
    end else if (busy) begin
      rem = rem - 1;
      if (rem == 0) begin
        busy = 1'b0;
        if (!hang) begin
          core_done       = 1'b1;
          core_ciphertext = present_ref(cap_pt, cap_key);
        end
      end
    end
    if (stray_req != stray_ack) begin
      stray_ack       = stray_req;
      core_done       = 1'b1;
      core_ciphertext = 64'hFEED_FACE_FEED_FACE;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [63:0] pt, input logic [79:0] key);
    req_plaintext[i*BLOCK_W +: BLOCK_W] = pt;
    req_key[i*KEY_W +: KEY_W]           = key;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (core_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_resp(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      n++;
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00 || resp_valid !== 1'b0 || resp_err !== 1'b0 || core_start !== 1'b0 || resp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b err=%b start=%b id=%0d, required all 0",
               req_ready, resp_valid, resp_err, core_start, resp_id);
    end
    checks++;
    if (resp_ciphertext !== 64'h0 || core_plaintext !== 64'h0 || core_key !== 80'h0) begin
      errors++;
      $display("FAIL reset_data: ct=%h pt=%h key=%h, required 0", resp_ciphertext, core_plaintext, core_key);
    end
  endtask

  task automatic test_reset_priority;
    bit ok;
    int n;
    lat = 3;
    set_req(0, PT_0, KEY_0);
    set_req(1, PT_0, KEY_F);
    req_valid = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL prio_ready: req_ready=%b, required 01", req_ready);
    end
    wait_start(ok);
    wait_resp(n, ok);
    checks++;
    if (!ok || n !== lat + 1) begin
      errors++;
      $display("FAIL prio_latency: ok=%0d cycles=%0d, required %0d", ok, n, lat + 1);
    end
    checks++;
    if (resp_id !== 1'b0 || resp_ciphertext !== 64'h5579C1387B228445 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL prio_first: id=%0d ct=%h err=%b, required id 0 ct 5579c1387b228445 err 0",
               resp_id, resp_ciphertext, resp_err);
    end
    wait_start(ok);
    wait_resp(n, ok);
    req_valid = 2'b00;
    checks++;
    if (!ok || resp_id !== 1'b1 || resp_ciphertext !== 64'hE72C46C0F5945049 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL prio_second: ok=%0d id=%0d ct=%h err=%b, required id 1 ct e72c46c0f5945049 err 0",
               ok, resp_id, resp_ciphertext, resp_err);
    end
  endtask

  task automatic test_round_robin;
    logic [ID_W-1:0] ids[4];
    logic [63:0]     cts[4];
    logic [ID_W-1:0] exp_id[4];
    logic [63:0]     exp_ct[4];
    int  jobs = 0;
    int  starts = 0;
    int  viol = 0;
    bit  inflight = 1'b0;
    bit  prev_start = 1'b0;
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_ct = '{64'hA112FFC72F68417B, 64'h3333DCD3213210D2, 64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
    lat = 2;
    @(negedge clk);
    set_req(0, PT_F, KEY_0);
    set_req(1, PT_F, KEY_F);
    req_valid = 2'b11;
    for (int c = 0; c < 400 && jobs < 4; c++) begin
      #1;
      if ($countones(req_ready) > 1) viol++;
      if (req_ready !== 2'b00 && (inflight || core_start || resp_valid)) viol++;
      if (core_start && prev_start) viol++;
      prev_start = core_start;
      if (core_start) begin
        starts++;
        inflight = 1'b1;
      end
      if (resp_valid) begin
        ids[jobs] = resp_id;
        cts[jobs] = resp_ciphertext;
        jobs++;
        inflight = 1'b0;
        if (jobs == 4) req_valid = 2'b00;
      end
      @(negedge clk);
    end
    checks++;
    if (jobs !== 4 || starts !== 4 || viol !== 0) begin
      errors++;
      $display("FAIL rr_protocol: jobs=%0d starts=%0d violations=%0d, required 4 4 0", jobs, starts, viol);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (ids[j] !== exp_id[j] || cts[j] !== exp_ct[j]) begin
        errors++;
        $display("FAIL rr_job%0d: id=%0d ct=%h, required id %0d ct %h", j, ids[j], cts[j], exp_id[j], exp_ct[j]);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int n;
    int viol = 0;
    lat = 4;
    resp_ready = 1'b0;
    set_req(0, PT_F, KEY_0);
    req_valid = 2'b01;
    wait_resp(n, ok);
    checks++;
    if (!ok || resp_id !== 1'b0 || resp_ciphertext !== 64'hA112FFC72F68417B || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_resp: ok=%0d id=%0d ct=%h err=%b, required id 0 ct a112ffc72f68417b err 0",
               ok, resp_id, resp_ciphertext, resp_err);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_ciphertext !== 64'hA112FFC72F68417B || req_ready !== 2'b00)
        viol++;
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL bp_hold: unstable cycles=%0d, required 0", viol);
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL bp_ready_early: req_ready=%b during handshake cycle, required 00", req_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_after: resp_valid=%b req_ready=%b, required 0 and 01", resp_valid, req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    hang = 1'b1;
    lat = 3;
    set_req(0, PT_0, KEY_0);
    req_valid = 2'b01;
    wait_start(ok);
    req_valid = 2'b00;
    wait_resp(n, ok);
    checks++;
    if (!ok || n !== TO + 1) begin
      errors++;
      $display("FAIL to_latency: ok=%0d cycles=%0d, required %0d", ok, n, TO + 1);
    end
    checks++;
    if (resp_err !== 1'b1 || resp_ciphertext !== 64'h0 || resp_id !== 1'b0) begin
      errors++;
      $display("FAIL to_resp: err=%b ct=%h id=%0d, required err 1 ct 0 id 0", resp_err, resp_ciphertext, resp_id);
    end
    hang = 1'b0;
    set_req(1, PT_F, KEY_F);
    req_valid = 2'b10;
    wait_start(ok);
    req_valid = 2'b00;
    wait_resp(n, ok);
    checks++;
    if (!ok || resp_err !== 1'b0 || resp_ciphertext !== 64'h3333DCD3213210D2 || resp_id !== 1'b1) begin
      errors++;
      $display("FAIL to_recover: ok=%0d err=%b ct=%h id=%0d, required err 0 ct 3333dcd3213210d2 id 1",
               ok, resp_err, resp_ciphertext, resp_id);
    end
  endtask

  task automatic test_reset_mid_job;
    bit ok;
    int n;
    int viol = 0;
    lat = 20;
    set_req(1, PT_F, KEY_F);
    req_valid = 2'b10;
    wait_start(ok);
    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_err, core_start} !== '0 || resp_ciphertext !== 64'h0 ||
        core_plaintext !== 64'h0 || core_key !== 80'h0) begin
      errors++;
      $display("FAIL midrst_outputs: ready=%b valid=%b id=%0d err=%b start=%b ct=%h pt=%h key=%h, required all 0",
               req_ready, resp_valid, resp_id, resp_err, core_start, resp_ciphertext, core_plaintext, core_key);
    end
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (c == 2) stray_req++;
      if (resp_valid !== 1'b0 || core_start !== 1'b0) viol++;
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL midrst_stale: spurious activity cycles=%0d, required 0", viol);
    end
    lat = 3;
    set_req(0, PT_0, KEY_0);
    set_req(1, PT_F, KEY_F);
    req_valid = 2'b11;
    wait_start(ok);
    req_valid = 2'b00;
    wait_resp(n, ok);
    checks++;
    if (!ok || resp_id !== 1'b0 || resp_ciphertext !== 64'h5579C1387B228445 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next: ok=%0d id=%0d ct=%h err=%b, required id 0 ct 5579c1387b228445 err 0",
               ok, resp_id, resp_ciphertext, resp_err);
    end
  endtask

  task automatic test_done_timeout_collision;
    bit ok;
    int n;
    lat = TO;
    set_req(1, PT_0, KEY_F);
    req_valid = 2'b10;
    wait_start(ok);
    req_valid = 2'b00;
    wait_resp(n, ok);
    checks++;
    if (!ok || n !== TO + 1) begin
      errors++;
      $display("FAIL coll_latency: ok=%0d cycles=%0d, required %0d", ok, n, TO + 1);
    end
    checks++;
    if (resp_err !== 1'b0 || resp_ciphertext !== 64'hE72C46C0F5945049 || resp_id !== 1'b1) begin
      errors++;
      $display("FAIL coll_resp: err=%b ct=%h id=%0d, required err 0 ct e72c46c0f5945049 id 1",
               resp_err, resp_ciphertext, resp_id);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    req_valid     = '0;
    req_plaintext = '0;
    req_key       = '0;
    resp_ready    = 1'b1;
    lat           = 3;
    hang          = 1'b0;
    stray_req     = 0;
    test_reset;
    test_reset_priority;
    test_round_robin;
    test_backpressure;
    test_timeout;
    test_reset_mid_job;
    test_done_timeout_collision;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
